// File: rtl/conv3_pkg.sv
// Shared constants, width derivations and FSM state encoding for the conv3 result packer.
package conv3_pkg;

  localparam int DEFAULT_PRECISION_WIDTH = 4;
  localparam int LANES_PER_WORD          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_READ,
    ST_PUSH,
    ST_FIN
  } state_e;

  function automatic int conv3_sum_width(input int precision_width);
    return 2 * precision_width + 4;
  endfunction

  // Each block of eight results occupies nine words, after a two-word header.
  function automatic int conv3_result_base(input int kernel_num);
    return 2 + 9 * (kernel_num / LANES_PER_WORD);
  endfunction

  // Control registers sit at the very top of the convolution address map.
  function automatic int conv3_done_addr(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

  function automatic int conv3_start_addr(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

  function automatic int conv3_clear_addr(input int addr_width);
    return (1 << addr_width) - 3;
  endfunction

endpackage

// File: rtl/conv3_requant.sv
// Requantizer: arithmetic right shift of a signed sum, truncation, then saturation.
// Defining CONV3_PACKER_RELU_EN selects unsigned ReLU clamping instead of signed clamping.
module conv3_requant
  import conv3_pkg::*;
#(
  parameter int PRECISION_WIDTH = DEFAULT_PRECISION_WIDTH,
  parameter int SUM_WIDTH       = conv3_sum_width(PRECISION_WIDTH),
  parameter int SHIFT_WIDTH     = $clog2(SUM_WIDTH)
) (
  input  logic [SUM_WIDTH-1:0]       i_sum,
  input  logic [SHIFT_WIDTH-1:0]     i_shift,
  output logic [PRECISION_WIDTH-1:0] o_q
);

  logic signed [SUM_WIDTH-1:0] shifted;

  assign shifted = $signed(i_sum) >>> i_shift;

`ifdef CONV3_PACKER_RELU_EN
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((1 << PRECISION_WIDTH) - 1);

  always_comb begin
    o_q = shifted[PRECISION_WIDTH-1:0];
    if (shifted[SUM_WIDTH-1]) begin
      o_q = '0;
    end else if (shifted > SAT_MAX) begin
      o_q = '1;
    end
  end
`else
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((1 << (PRECISION_WIDTH - 1)) - 1);
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = SUM_WIDTH'(-(1 << (PRECISION_WIDTH - 1)));

  always_comb begin
    o_q = shifted[PRECISION_WIDTH-1:0];
    if (shifted < SAT_MIN) begin
      o_q = SAT_MIN[PRECISION_WIDTH-1:0];
    end else if (shifted > SAT_MAX) begin
      o_q = SAT_MAX[PRECISION_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: rtl/conv3_result_packer.sv
// Polls the convolution done flag, reads results, requantizes and packs eight per output word.
// Saturation mode is selected by the CONV3_PACKER_RELU_EN macro inside conv3_requant.
module conv3_result_packer
  import conv3_pkg::*;
#(
  parameter int PRECISION_WIDTH  = DEFAULT_PRECISION_WIDTH,
  parameter int VALID_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH       = 32,
  parameter int KERNEL_NUM       = 112
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  input  logic                                     i_abort,
  input  logic [$clog2(2*PRECISION_WIDTH+4)-1:0]   i_shift,
  output logic                                     o_re,
  output logic [VALID_ADDR_WIDTH-1:0]              o_read_addr,
  input  logic [DATA_WIDTH-1:0]                    i_rdata,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [DATA_WIDTH-1:0]                    o_data,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int SUM_WIDTH   = conv3_sum_width(PRECISION_WIDTH);
  localparam int SHIFT_WIDTH = $clog2(SUM_WIDTH);
  localparam int RESULT_BASE = conv3_result_base(KERNEL_NUM);
  localparam int IDX_WIDTH   = $clog2(KERNEL_NUM + 1);
  localparam int LANE_WIDTH  = $clog2(LANES_PER_WORD);

  localparam logic [VALID_ADDR_WIDTH-1:0] DONE_ADDR =
    VALID_ADDR_WIDTH'(conv3_done_addr(VALID_ADDR_WIDTH));
  localparam logic [VALID_ADDR_WIDTH-1:0] BASE_ADDR = VALID_ADDR_WIDTH'(RESULT_BASE);

  state_e                     state_q, state_d;
  logic [IDX_WIDTH-1:0]       idx_q, idx_d;
  logic [LANE_WIDTH-1:0]      lane_q, lane_d;
  logic [DATA_WIDTH-1:0]      pack_q, pack_d;
  logic [SHIFT_WIDTH-1:0]     shift_q, shift_d;
  logic [PRECISION_WIDTH-1:0] req_value;
  logic                       unused_rdata;

  // Bits above the accumulator width carry nothing this block needs.
  assign unused_rdata = ^i_rdata[DATA_WIDTH-1:SUM_WIDTH];

  conv3_requant #(
    .PRECISION_WIDTH (PRECISION_WIDTH),
    .SUM_WIDTH       (SUM_WIDTH),
    .SHIFT_WIDTH     (SHIFT_WIDTH)
  ) u_requant (
    .i_sum   (i_rdata[SUM_WIDTH-1:0]),
    .i_shift (shift_q),
    .o_q     (req_value)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    shift_d     = shift_q;
    o_re        = 1'b0;
    o_read_addr = '0;
    o_valid     = 1'b0;
    o_done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          shift_d = i_shift;
          idx_d   = '0;
          lane_d  = '0;
          pack_d  = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        o_re        = 1'b1;
        o_read_addr = DONE_ADDR;
        if (i_rdata[0]) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        o_re        = 1'b1;
        o_read_addr = BASE_ADDR + VALID_ADDR_WIDTH'(idx_q);
        // Lane 0 lands in the most significant slot of the word.
        for (int l = 0; l < LANES_PER_WORD; l++) begin
          if (lane_q == LANE_WIDTH'(l)) begin
            pack_d[DATA_WIDTH-1-l*PRECISION_WIDTH -: PRECISION_WIDTH] = req_value;
          end
        end
        idx_d  = idx_q + 1'b1;
        lane_d = lane_q + 1'b1;
        if (lane_q == LANE_WIDTH'(LANES_PER_WORD - 1)) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = (idx_q == IDX_WIDTH'(KERNEL_NUM)) ? ST_FIN : ST_READ;
        end
      end
      ST_FIN: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      lane_d  = '0;
      pack_d  = '0;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_data = pack_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_conv3_result_packer.sv
// Scoreboard bench for conv3_result_packer: directed jobs with a combinational memory model.
// Expected values follow the CONV3_PACKER_RELU_EN setting of the build.
module tb_conv3_result_packer;

  localparam int PW          = 4;
  localparam int AW          = 14;
  localparam int DW          = 32;
  localparam int KN          = 112;
  localparam int RESULT_BASE = 2 + 9 * (KN / 8);
  localparam logic [AW-1:0] DONE_ADDR = 14'h3FFF;

  typedef struct {
    int words;
    int cycles;
  } doneExp_t;

  logic          clk;
  logic          rstN;
  logic          start;
  logic          abort;
  logic [3:0]    shift;
  logic          re;
  logic [AW-1:0] readAddr;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;

  logic          doneFlag;
  logic [11:0]   mem [0:KN-1];

  logic [31:0]   expWords[$];
  doneExp_t      doneQ[$];

  int testsRun   = 0;
  int failCount  = 0;
  int pollReads  = 0;
  int dataReads  = 0;
  int busyCount  = 0;
  int wordCount  = 0;
  int doneEvents = 0;

  conv3_result_packer #(
    .PRECISION_WIDTH  (PW),
    .VALID_ADDR_WIDTH (AW),
    .DATA_WIDTH       (DW),
    .KERNEL_NUM       (KN)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (start),
    .i_abort     (abort),
    .i_shift     (shift),
    .o_re        (re),
    .o_read_addr (readAddr),
    .i_rdata     (rdata),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_data      (data),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: done flag at the top address, results with junk in the upper bits.
  always_comb begin
    rdata = '0;
    if (readAddr == DONE_ADDR) begin
      rdata = {31'd0, doneFlag};
    end else if (int'(readAddr) >= RESULT_BASE && int'(readAddr) < RESULT_BASE + KN) begin
      rdata = {20'hABCDE, mem[int'(readAddr) - RESULT_BASE]};
    end
  end

  function automatic logic [3:0] modelNibble(input logic [11:0] sum, input int sh);
    int v;
    v = $signed(sum);
    v = v >>> sh;
`ifdef CONV3_PACKER_RELU_EN
    if (v < 0) v = 0;
    else if (v > 15) v = 15;
`else
    if (v < -8) v = -8;
    else if (v > 7) v = 7;
`endif
    return 4'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Queues the expected words of a job (word 0 hand-computed) and pulses start.
  task automatic applyStimulus(input logic [3:0] sh, input bit expectDone,
                               input int expCycles, input logic [31:0] firstWord);
    logic [31:0] w;
    doneExp_t    d;
    if (expectDone) begin
      expWords.push_back(firstWord);
      for (int wi = 1; wi < KN / 8; wi++) begin
        w = '0;
        for (int l = 0; l < 8; l++) begin
          w[31-4*l -: 4] = modelNibble(mem[wi*8+l], int'(sh));
        end
        expWords.push_back(w);
      end
      d.words  = KN / 8;
      d.cycles = expCycles;
      doneQ.push_back(d);
    end
    @(posedge clk); #1;
    start     = 1'b1;
    shift     = sh;
    pollReads = 0;
    dataReads = 0;
    busyCount = 0;
    wordCount = 0;
    @(posedge clk); #1;
    start = 1'b0;
    shift = 4'd9;
  endtask

  task automatic waitDone(input int budget, input string name);
    int  startCount;
    bit  seen;
    startCount = doneEvents;
    seen       = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (doneEvents != startCount) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL %s: no done pulse within %0d cycles", name, budget);
    end
    #1;
  endtask

  task automatic waitValid(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL %s: no valid within %0d cycles", name, budget);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word and on each done pulse.
  always @(negedge clk) begin
    logic [31:0] expWord;
    doneExp_t    d;
    if (busy) busyCount++;
    if (re && readAddr == DONE_ADDR) pollReads++;
    if (re && readAddr != DONE_ADDR) dataReads++;
    if (valid && ready) begin
      if (expWords.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpectedWord: got %h, expected no word", data);
      end else begin
        expWord = expWords.pop_front();
        checkOutput("packedWord", data, expWord);
      end
      wordCount++;
    end
    if (done) begin
      doneEvents++;
      if (doneQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpectedDone: got done pulse, expected none");
      end else begin
        d = doneQ.pop_front();
        checkOutput("doneWordCount", 32'(wordCount), 32'(d.words));
        checkOutput("jobBusyCycles", 32'(busyCount), 32'(d.cycles));
      end
    end
  end

  initial begin
    logic [31:0] heldData;
    logic [AW-1:0] heldAddr;

    rstN     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    shift    = '0;
    ready    = 1'b1;
    doneFlag = 1'b0;
    for (int k = 0; k < KN; k++) mem[k] = '0;

    #3;
    checkOutput("resetRe",    32'(re),       32'd0);
    checkOutput("resetAddr",  32'(readAddr), 32'd0);
    checkOutput("resetValid", 32'(valid),    32'd0);
    checkOutput("resetData",  data,          32'd0);
    checkOutput("resetBusy",  32'(busy),     32'd0);
    checkOutput("resetDone",  32'(done),     32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Job A: shift 0, results 1..8 in word 0, done flag held low for 10 poll cycles.
    for (int k = 0; k < KN; k++) mem[k] = 12'(k * 5 - 200);
    for (int k = 0; k < 8; k++) mem[k] = 12'(k + 1);
`ifdef CONV3_PACKER_RELU_EN
    applyStimulus(4'd0, 1'b1, 138, 32'h12345678);
`else
    applyStimulus(4'd0, 1'b1, 138, 32'h12345677);
`endif
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pollReadCount", 32'(pollReads), 32'd10);
    checkOutput("pollNoDataRead", 32'(dataReads), 32'd0);
    checkOutput("pollAddr", 32'(readAddr), 32'(DONE_ADDR));
    doneFlag = 1'b1;
    waitDone(300, "jobA");

    // Job B: shift 2, saturation and negative sums, 5 cycles of backpressure on word 0.
    for (int k = 0; k < KN; k++) mem[k] = 12'(k * 29 - 1500);
    mem[0] = 12'h0FF; mem[1] = 12'h028; mem[2] = 12'hFF0; mem[3] = 12'h004;
    mem[4] = 12'h000; mem[5] = 12'h7FF; mem[6] = 12'h800; mem[7] = 12'h01C;
    ready = 1'b0;
`ifdef CONV3_PACKER_RELU_EN
    applyStimulus(4'd2, 1'b1, 133, 32'hFA010F07);
`else
    applyStimulus(4'd2, 1'b1, 133, 32'h77C10787);
`endif
    waitValid(40, "jobBValid");
    heldData = data;
    heldAddr = readAddr;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("stallValid", 32'(valid), 32'd1);
      checkOutput("stallData", data, heldData);
      checkOutput("stallRe", 32'(re), 32'd0);
      checkOutput("stallAddr", 32'(readAddr), 32'(heldAddr));
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("afterAcceptValid", 32'(valid), 32'd0);
    checkOutput("afterAcceptRe", 32'(re), 32'd1);
    checkOutput("afterAcceptAddr", 32'(readAddr), 32'(RESULT_BASE + 8));
    waitDone(300, "jobB");

    // Job C: abort on the fourth READ cycle; no word and no done are expected.
    applyStimulus(4'd0, 1'b0, 0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("fourthReadAddr", 32'(readAddr), 32'(RESULT_BASE + 3));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortValid", 32'(valid), 32'd0);
    checkOutput("abortRe", 32'(re), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Job D: fresh start restarts at the base address, then async reset mid-PUSH.
    ready = 1'b0;
    applyStimulus(4'd0, 1'b0, 0, 32'd0);
    @(posedge clk); #1;
    checkOutput("restartRe", 32'(re), 32'd1);
    checkOutput("restartAddr", 32'(readAddr), 32'(RESULT_BASE));
    waitValid(40, "jobDValid");
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRe",    32'(re),       32'd0);
    checkOutput("asyncAddr",  32'(readAddr), 32'd0);
    checkOutput("asyncValid", 32'(valid),    32'd0);
    checkOutput("asyncData",  data,          32'd0);
    checkOutput("asyncBusy",  32'(busy),     32'd0);
    checkOutput("asyncDone",  32'(done),     32'd0);
    @(posedge clk); #1;
    rstN  = 1'b1;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("postResetBusy", 32'(busy), 32'd0);

    checkOutput("leftoverWords", 32'(expWords.size()), 32'd0);
    checkOutput("leftoverDones", 32'(doneQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/conv3_result_packer.md
CONV3_RESULT_PACKER -- requirements
Module: conv3_result_packer

Interface
REQ-001 SHALL have parameter PRECISION_WIDTH, default 4, meaning bits per quantized output value.
REQ-002 SHALL have parameter VALID_ADDR_WIDTH, default 14, meaning convolution memory-interface address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning bus and output word width.
REQ-004 SHALL have parameter KERNEL_NUM, default 112, meaning result count, a multiple of 8.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_start, input, 1 bit: single-cycle job request.
REQ-008 SHALL have port i_abort, input, 1 bit: cancel the current job.
REQ-009 SHALL have port i_shift, input, $clog2(2*PRECISION_WIDTH+4) bits: right-shift amount.
REQ-010 SHALL have port o_re, output, 1 bit: read enable to the memory interface.
REQ-011 SHALL have port o_read_addr, output, VALID_ADDR_WIDTH bits: read address.
REQ-012 SHALL have port i_rdata, input, DATA_WIDTH bits: read data, combinationally valid in the same cycle as o_re.
REQ-013 SHALL have port o_valid, output, 1 bit: packed word available.
REQ-014 SHALL have port i_ready, input, 1 bit: downstream accepts the word.
REQ-015 SHALL have port o_data, output, DATA_WIDTH bits: packed word.
REQ-016 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port o_done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-018 SHALL derive SUM_WIDTH = 2*PRECISION_WIDTH+4, RESULT_BASE = 2+9*(KERNEL_NUM/8), and DONE_ADDR = 2**VALID_ADDR_WIDTH-1.
REQ-019 SHALL implement the states IDLE, POLL, READ, PUSH and FIN.
REQ-020 SHALL, in IDLE with i_start=1, latch i_shift, clear the index and lane counters, and enter POLL on the next cycle; i_start outside IDLE SHALL be ignored.
REQ-021 SHALL, in POLL, drive o_re=1 and o_read_addr=DONE_ADDR every cycle, and enter READ when i_rdata[0]=1; there is no timeout.
REQ-022 SHALL, in READ, drive o_re=1 and o_read_addr=RESULT_BASE+idx, capture the requantized value of i_rdata[SUM_WIDTH-1:0] into lane, then increment idx and lane; after lane 7 it SHALL enter PUSH.
REQ-023 SHALL requantize as follows: treat the sum as signed SUM_WIDTH, apply an arithmetic right shift by the latched shift, truncate with no rounding, then saturate per REQ-033.
REQ-024 SHALL pack lane 0 in o_data[DATA_WIDTH-1 -: PRECISION_WIDTH], MSB-first, with lane 7 in the LSBs.
REQ-025 SHALL, in PUSH, hold o_valid=1 with o_data stable until i_ready=1; on acceptance it SHALL enter FIN if idx==KERNEL_NUM, otherwise READ; o_re=0 throughout PUSH.
REQ-026 SHALL, in FIN, assert o_done for exactly one cycle, then return to IDLE.
REQ-027 SHALL set job latency to at least 1 poll cycle plus (KERNEL_NUM/8)*9 cycles plus 1 FIN cycle, with no backpressure.
REQ-028 SHALL, on i_abort=1 in any state, return to IDLE on the next edge, discard the partial word, drop o_valid, and not pulse o_done; i_abort SHALL win over a simultaneous i_start.
REQ-029 SHALL drive o_re=0 and o_valid=0 in IDLE and FIN.

Reset
REQ-030 SHALL, on i_rst_n=0 and without waiting for a clock edge, force state=IDLE, idx=0, lane=0, pack register=0 and latched shift=0.
REQ-031 SHALL force o_re=0, o_read_addr=0, o_valid=0, o_data=0, o_busy=0 and o_done=0 while in reset.
REQ-032 SHALL, on reset mid-job, abandon the job without an o_done pulse.

Configuration
REQ-033 SHALL, with CONV3_PACKER_RELU_EN defined, saturate to [0, 2**PRECISION_WIDTH-1], so negatives yield 0; without it, SHALL saturate signed to [-2**(PRECISION_WIDTH-1), 2**(PRECISION_WIDTH-1)-1] in two's complement.

Structure
REQ-034 SHALL place PRECISION_WIDTH defaults, the SUM_WIDTH and RESULT_BASE derivations, the DONE/START/CLEAR address constants and the state enum in shared package conv3_pkg.
REQ-035 SHALL implement the shift and saturate as one combinational sub-module, conv3_requant, instantiated once.

Verification
REQ-036 SHALL verify packing: shift=0, results 1..8, then i_ready=1 -> o_data=32'h12345678, and the FIN o_done pulse arrives after 14 words.
REQ-037 SHALL verify saturation: shift=2, sum 12'h0FF -> nibble 4'hF; sum 12'h028 -> 4'hA.
REQ-038 SHALL verify negative handling: sum 12'hFF0 with shift=2 -> 4'h0 with CONV3_PACKER_RELU_EN, 4'hC without it.
REQ-039 SHALL verify backpressure: i_ready=0 for 5 cycles in PUSH -> o_data stable, o_re=0, no address advance; the word is accepted on the first cycle with i_ready=1.
REQ-040 SHALL verify abort: i_abort on the fourth READ cycle -> IDLE next cycle, o_valid=0, no o_done, and a fresh i_start restarts at RESULT_BASE.
REQ-041 SHALL verify polling and reset: done held 0 for 10 cycles -> 10 reads of DONE_ADDR and no READ; async reset asserted mid-PUSH -> all outputs 0 immediately, without a clock edge.
